id_issue_queue: RTL and testbench

Parametrised successor to the single-entry ID pipeline register: a DEPTH-entry FIFO of decoded instructions sitting between decode/regfile read and EX.
- Valid/ready handshake on both sides replaces the global stall_n load enable.
- Queued source operands snoop the writeback bus, so entries never hold stale register values.
- Branch flush empties the whole queue in one cycle.

---
 rtl/rv32i_types.sv | 40 ++++
 rtl/id_issue_queue_entry.sv | 43 ++++
 rtl/id_issue_queue.sv | 143 ++++++++++++++
 tb/tb_id_issue_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I decode types: control word, issue-queue entry, snoop-match helper.
// Optional ID_ISSUE_QUEUE_RVFI_EN adds the rvfi_mon_word monitor record.
package rv32i_types;

  localparam int unsigned XLEN                  = 32;
  localparam int unsigned REG_ADDR_W            = 5;
  localparam int unsigned CTRL_WORD_W           = 64;
  localparam int unsigned CTRL_LOAD_REGFILE_BIT = 0;

  typedef logic [CTRL_WORD_W-1:0] rv32i_control_word;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    rv32i_control_word     ctrl;
  } iq_entry_t;

`ifdef ID_ISSUE_QUEUE_RVFI_EN
  typedef struct packed {
    logic [31:0]           insn;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  load_regfile;
  } rvfi_mon_word;
`endif

  // x0 is hardwired, so a writeback to it never forwards.
  function automatic logic snoop_hit(input logic                  wb_valid,
                                     input logic [REG_ADDR_W-1:0] wb_rd,
                                     input logic [REG_ADDR_W-1:0] rs);
    return wb_valid && (wb_rd != '0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/id_issue_queue_entry.sv
// One issue-queue slot: load on push, clear on flush, snoop writeback while occupied.
// Optional ID_ISSUE_QUEUE_RVFI_EN adds a monitor word carried with the slot.
module id_issue_queue_entry
  import rv32i_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  occupied,
  input  iq_entry_t             load_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
`ifdef ID_ISSUE_QUEUE_RVFI_EN
  input  rvfi_mon_word          load_rvfi,
  output rvfi_mon_word          rvfi,
`endif
  output iq_entry_t             q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (occupied) begin
      if (snoop_hit(wb_valid, wb_rd, q.rs1)) q.rs1_data <= wb_data;
      if (snoop_hit(wb_valid, wb_rd, q.rs2)) q.rs2_data <= wb_data;
    end
  end

`ifdef ID_ISSUE_QUEUE_RVFI_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rvfi <= '0;
    else if (clear) rvfi <= '0;
    else if (load)  rvfi <= load_rvfi;
  end
`endif

endmodule

// File: rtl/id_issue_queue.sv
// DEPTH-entry decode-to-EX issue FIFO with writeback snoop, head bypass and one-cycle flush.
// Width parameters must match the rv32i_types widths; ID_ISSUE_QUEUE_RVFI_EN adds rvfi ports.
module id_issue_queue
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned RADDR  = 5,
  parameter int unsigned CTRL_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [RADDR-1:0]           in_rs1,
  input  logic [RADDR-1:0]           in_rs2,
  input  logic [RADDR-1:0]           in_rd,
  input  logic [WIDTH-1:0]           in_rs1_data,
  input  logic [WIDTH-1:0]           in_rs2_data,
  input  logic [WIDTH-1:0]           in_imm,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic                       wb_valid,
  input  logic [RADDR-1:0]           wb_rd,
  input  logic [WIDTH-1:0]           wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_pc,
  output logic [RADDR-1:0]           out_rs1,
  output logic [RADDR-1:0]           out_rs2,
  output logic [RADDR-1:0]           out_rd,
  output logic [WIDTH-1:0]           out_rs1_data,
  output logic [WIDTH-1:0]           out_rs2_data,
  output logic [WIDTH-1:0]           out_imm,
  output logic [CTRL_W-1:0]          out_ctrl,
`ifdef ID_ISSUE_QUEUE_RVFI_EN
  input  rvfi_mon_word               rvfi_word_in,
  output rvfi_mon_word               rvfi_word_out,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  iq_entry_t        push_entry;
  iq_entry_t        head_entry;
  iq_entry_t        slots [DEPTH];

  assign in_ready  = (count < CNT_W'(DEPTH)) || out_ready;
  assign out_valid = (count != '0) && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Write-through: a writeback landing in the push cycle is captured instead of the stale read.
  always_comb begin
    push_entry          = '0;
    push_entry.pc       = in_pc;
    push_entry.rs1      = in_rs1;
    push_entry.rs2      = in_rs2;
    push_entry.rd       = in_rd;
    push_entry.rs1_data = snoop_hit(wb_valid, wb_rd, in_rs1) ? wb_data : in_rs1_data;
    push_entry.rs2_data = snoop_hit(wb_valid, wb_rd, in_rs2) ? wb_data : in_rs2_data;
    push_entry.imm      = in_imm;
    push_entry.ctrl     = in_ctrl;
  end

`ifdef ID_ISSUE_QUEUE_RVFI_EN
  rvfi_mon_word push_rvfi;
  rvfi_mon_word rvfi_slots [DEPTH];

  always_comb begin
    push_rvfi              = rvfi_word_in;
    push_rvfi.rs1_addr     = in_rs1;
    push_rvfi.rs2_addr     = in_rs2;
    push_rvfi.rd_addr      = in_rd;
    push_rvfi.load_regfile = in_ctrl[CTRL_LOAD_REGFILE_BIT];
  end

  assign rvfi_word_out = out_valid ? rvfi_slots[head] : '0;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] offset;
    logic             occupied;
    logic             load;

    // Slot is live when its distance from head is below the fill level.
    assign offset   = PTR_W'(i) - head;
    assign occupied = CNT_W'(offset) < count;
    assign load     = push && (tail == PTR_W'(i));

    id_issue_queue_entry u_entry (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (load),
      .occupied  (occupied),
      .load_data (push_entry),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
`ifdef ID_ISSUE_QUEUE_RVFI_EN
      .load_rvfi (push_rvfi),
      .rvfi      (rvfi_slots[i]),
`endif
      .q         (slots[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_entry   = slots[head];
  assign out_pc       = head_entry.pc;
  assign out_rs1      = head_entry.rs1;
  assign out_rs2      = head_entry.rs2;
  assign out_rd       = head_entry.rd;
  assign out_imm      = head_entry.imm;
  assign out_rs1_data = snoop_hit(wb_valid, wb_rd, head_entry.rs1) ? wb_data : head_entry.rs1_data;
  assign out_rs2_data = snoop_hit(wb_valid, wb_rd, head_entry.rs2) ? wb_data : head_entry.rs2_data;
  assign out_ctrl     = out_valid ? head_entry.ctrl : '0;

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed scenarios plus random traffic vs a queue model.
module tb_id_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [63:0] in_ctrl;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [31:0] out_imm;
  logic [63:0] out_ctrl;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [63:0] ctrl;
  } item_t;

  item_t mq[$];

  id_issue_queue #(.WIDTH(32), .DEPTH(4), .RADDR(5), .CTRL_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_rd        (in_rd),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_ctrl      (in_ctrl),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_ctrl     (out_ctrl),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fwd(input logic [4:0] rs);
    return wb_valid && (wb_rd != 5'd0) && (wb_rd == rs);
  endfunction

  // Compare all visible outputs against the model for the current (settled) inputs.
  task automatic check_outputs();
    int   n;
    logic ev;
    item_t h;
    n  = mq.size();
    ev = (n != 0) && !flush;
    check("count", 64'(count), 64'(n));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("in_ready", 64'(in_ready), 64'((n < 4) || out_ready));
    checks++;
    assert (count <= 3'd4) else begin
      errors++;
      $error("FAIL count_bound observed %0d expected <=4", count);
    end
    if (ev) begin
      h = mq[0];
      check("out_pc", 64'(out_pc), 64'(h.pc));
      check("out_rs1", 64'(out_rs1), 64'(h.rs1));
      check("out_rs2", 64'(out_rs2), 64'(h.rs2));
      check("out_rd", 64'(out_rd), 64'(h.rd));
      check("out_imm", 64'(out_imm), 64'(h.imm));
      check("out_ctrl", out_ctrl, h.ctrl);
      check("out_rs1_data", 64'(out_rs1_data), 64'(fwd(h.rs1) ? wb_data : h.d1));
      check("out_rs2_data", 64'(out_rs2_data), 64'(fwd(h.rs2) ? wb_data : h.d2));
    end else begin
      check("out_ctrl_bubble", out_ctrl, 64'd0);
    end
  endtask

  // Apply the queue rules for the inputs held across the edge just taken.
  task automatic model_edge();
    logic  do_pop;
    logic  do_push;
    item_t it;
    if (flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && ((mq.size() < 4) || out_ready);
      foreach (mq[k]) begin
        if (fwd(mq[k].rs1)) mq[k].d1 = wb_data;
        if (fwd(mq[k].rs2)) mq[k].d2 = wb_data;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        it.pc   = in_pc;
        it.rs1  = in_rs1;
        it.rs2  = in_rs2;
        it.rd   = in_rd;
        it.d1   = fwd(in_rs1) ? wb_data : in_rs1_data;
        it.d2   = fwd(in_rs2) ? wb_data : in_rs2_data;
        it.imm  = in_imm;
        it.ctrl = in_ctrl;
        mq.push_back(it);
      end
    end
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    tick();
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = 5'($urandom_range(1, 31));
    in_rs1_data = d1;
    in_rs2_data = d2;
    in_imm      = $urandom;
    in_ctrl     = {$urandom, $urandom} | 64'd1;
  endtask

  task automatic quiet();
    in_valid  = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    quiet();
    drive(32'h0, 5'd0, 5'd0, 32'h0, 32'h0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ctrl", out_ctrl, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Fill four with EX stalled, then drain in order.
    for (int k = 0; k < 4; k++) begin
      drive(32'h60 + 32'(4 * k), 5'd1, 5'd2, $urandom, $urandom);
      step();
    end
    in_valid = 1'b0;
    #1;
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_pc", 64'(out_pc), 64'(32'h60 + 32'(4 * k)));
      tick();
    end
    #1;
    check("drained_count", 64'(count), 64'd0);
    tick();

    // Full queue pushing and popping together across the pointer wrap.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'h100 + 32'(4 * k), 5'd4, 5'd6, $urandom, $urandom);
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h200 + 32'(4 * k), 5'd4, 5'd6, $urandom, $urandom);
      #1;
      check("wrap_in_ready", 64'(in_ready), 64'd1);
      check("wrap_count", 64'(count), 64'd4);
      tick();
    end
    in_valid = 1'b0;
    repeat (5) step();

    // Queued snoop, and x0 never snooped.
    out_ready = 1'b0;
    drive(32'h300, 5'd5, 5'd9, 32'h11, 32'h22);
    step();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAB;
    step();
    wb_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("snoop_rs1", 64'(out_rs1_data), 64'hAB);
    tick();
    out_ready = 1'b0;
    drive(32'h304, 5'd0, 5'd9, 32'h11, 32'h22);
    step();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hAB;
    step();
    wb_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("x0_no_snoop", 64'(out_rs1_data), 64'h11);
    tick();

    // Write-through on push, then head bypass during pop.
    out_ready = 1'b0;
    drive(32'h400, 5'd8, 5'd7, 32'h55, 32'h1234);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE;
    step();
    in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("write_through_rs2", 64'(out_rs2_data), 64'hCAFE);
    tick();
    out_ready = 1'b0;
    drive(32'h404, 5'd3, 5'd9, 32'h99, 32'h77);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h42;
    #1;
    check("head_bypass_rs1", 64'(out_rs1_data), 64'h42);
    tick();
    wb_valid = 1'b0;
    step();

    // Flush with a push pending at count=3.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h500 + 32'(4 * k), 5'd1, 5'd2, $urandom, $urandom);
      step();
    end
    drive(32'hDEAD, 5'd1, 5'd2, $urandom, $urandom);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("post_flush_count", 64'(count), 64'd0);
    check("post_flush_valid", 64'(out_valid), 64'd0);
    tick();
    step();

    // Asynchronous reset mid-stream at count=2.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(32'h600 + 32'(4 * k), 5'd1, 5'd2, $urandom, $urandom);
      step();
    end
    in_valid = 1'b0;
    #1;
    check("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_ctrl", out_ctrl, 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_count", 64'(count), 64'd0);
    tick();

    // Random traffic with small register space for frequent snoop hits.
    for (int c = 0; c < 400; c++) begin
      drive($urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      wb_valid  = ($urandom_range(0, 1) != 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
